// File: rtl/lsu.sv
// Load/store unit: issues one aligned bus access per M-stage request, traps misaligned
// accesses and bounds each bus wait with a timeout that raises a bus error.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [1:0]  a_lo,
  output logic [1:0]  mode_o,
  output logic        done,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  function automatic logic is_misaligned(input logic [1:0] m, input logic [1:0] a);
    case (m)
      2'd1:    is_misaligned = 1'b0;
      2'd2:    is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] calc_be(input logic [1:0] m, input logic [1:0] a);
    case (m)
      2'd1:    calc_be = 4'b0001 << a;
      2'd2:    calc_be = a[1] ? 4'b1100 : 4'b0011;
      default: calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] m, input logic [31:0] d);
    case (m)
      2'd1:    calc_wdata = {4{d[7:0]}};
      2'd2:    calc_wdata = {2{d[15:0]}};
      default: calc_wdata = d;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  mode_r, alo_r;
  logic [15:0] cnt_r;
  logic        err_r;
  logic        accept_s, ack_s, timeout_s;

  // Next-state logic plus the combinational handshake/exception outputs
  always_comb begin
    state_s   = state_r;
    stall     = 1'b0;
    bus_req   = 1'b0;
    done      = 1'b0;
    exc       = 1'b0;
    exc_code  = 5'd0;
    accept_s  = 1'b0;
    ack_s     = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        // a request seen while reset is high is never accepted, so it must not stall or trap
        if (req && !reset) begin
          if (is_misaligned(mode, addr[1:0])) begin
            exc      = 1'b1;
            exc_code = we ? 5'd5 : 5'd4;
          end else begin
            stall    = 1'b1;
            accept_s = 1'b1;
            state_s  = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        // ack wins over a timeout expiring in the same cycle
        if (bus_ack) begin
          ack_s   = 1'b1;
          state_s = RESP;
        end else if (cnt_r == TO_LAST) begin
          timeout_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        done     = !err_r;
        exc      = err_r;
        exc_code = err_r ? 5'd7 : 5'd0;
        state_s  = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, captured bus request, wait counter and load-result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      mode_r    <= 2'd0;
      alo_r     <= 2'd0;
      cnt_r     <= 16'd0;
      err_r     <= 1'b0;
      rdata     <= 32'd0;
      a_lo      <= 2'd0;
      mode_o    <= 2'd0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        bus_we    <= we;
        mode_r    <= mode;
        alo_r     <= addr[1:0];
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= calc_be(mode, addr[1:0]);
        bus_wdata <= calc_wdata(mode, wdata);
        cnt_r     <= 16'd0;
        err_r     <= 1'b0;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + 16'd1;
      end
      if (ack_s) begin
        if (!bus_we) begin
          rdata <= bus_rdata;
        end
        a_lo   <= alo_r;
        mode_o <= mode_r;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses checked
// against a transaction-level model of the expected bus request and result.
module tb_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, req, we, bus_ack;
  logic [1:0]  mode;
  logic [31:0] addr, wdata, bus_rdata;
  logic        stall, done, exc, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [1:0]  a_lo, mode_o;
  logic [4:0]  exc_code;
  logic [3:0]  bus_be;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_alo, exp_mode;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .stall(stall), .rdata(rdata), .a_lo(a_lo), .mode_o(mode_o),
    .done(done), .exc(exc), .exc_code(exc_code), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; we = 1'b1; mode = 2'd0; addr = 32'h0000_0003;
    wdata = 32'hFFFF_FFFF; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({stall, done, exc, bus_req, bus_we} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {stall, done, exc, bus_req, bus_we});
    end
    checks++;
    if ({rdata, bus_addr, bus_wdata} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {rdata, bus_addr, bus_wdata});
    end
    checks++;
    if ({a_lo, mode_o, exc_code, bus_be} !== 13'd0) begin
      failures++;
      $display("FAIL reset_misc: got %h expected 0", {a_lo, mode_o, exc_code, bus_be});
    end
    reset = 1'b0; req = 1'b0; bus_ack = 1'b0;
    exp_rdata = 32'd0; exp_alo = 2'd0; exp_mode = 2'd0;
    step();
  endtask

  // k = WAIT cycle in which ack arrives (1..TO); 0 means never ack
  task automatic run_access(input logic a_we, input logic [1:0] a_mode,
                            input logic [31:0] a_addr, input logic [31:0] a_wdata,
                            input int k, input logic [31:0] a_rdat, input string name);
    int size;
    logic mis, timed_out;
    logic [3:0] exp_be;
    logic [31:0] exp_wd;
    size = (a_mode == 2'd1) ? 1 : (a_mode == 2'd2) ? 2 : 4;
    mis = (int'(a_addr[1:0]) % size) != 0;
    exp_be = 4'(((1 << size) - 1) << int'(a_addr[1:0]));
    if (size == 1) exp_wd = {24'd0, a_wdata[7:0]} * 32'h0101_0101;
    else if (size == 2) exp_wd = {16'd0, a_wdata[15:0]} * 32'h0001_0001;
    else exp_wd = a_wdata;

    req = 1'b1; we = a_we; mode = a_mode; addr = a_addr; wdata = a_wdata; bus_ack = 1'b0;
    @(negedge clk);
    if (mis) begin
      checks++;
      if ({exc, exc_code, stall, bus_req, done} !== {1'b1, (a_we ? 5'd5 : 5'd4), 3'b000}) begin
        failures++;
        $display("FAIL %s_misalign: got %b expected exc=1 code=%0d others 0", name,
                 {exc, exc_code, stall, bus_req, done}, a_we ? 5 : 4);
      end
      step();
      req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_req, stall, exc, done} !== 4'b0000) begin
        failures++;
        $display("FAIL %s_misalign_after: got %b expected 0000", name, {bus_req, stall, exc, done});
      end
      step();
      return;
    end
    checks++;
    if ({stall, exc, bus_req, done} !== 4'b1000) begin
      failures++;
      $display("FAIL %s_accept: got %b expected 1000", name, {stall, exc, bus_req, done});
    end
    step();
    timed_out = 1'b1;
    for (int c = 1; c <= TO; c++) begin
      bus_ack = (c == k);
      bus_rdata = (c == k) ? a_rdat : $urandom;
      @(negedge clk);
      checks++;
      if ({bus_req, stall, done, bus_we, bus_addr, bus_be, bus_wdata} !==
          {1'b1, 1'b1, 1'b0, a_we, (a_addr & 32'hFFFF_FFFC), exp_be, exp_wd}) begin
        failures++;
        $display("FAIL %s_wait%0d: got req=%b stall=%b done=%b we=%b addr=%h be=%b wd=%h expected 1 1 0 %b %h %b %h",
                 name, c, bus_req, stall, done, bus_we, bus_addr, bus_be, bus_wdata,
                 a_we, a_addr & 32'hFFFF_FFFC, exp_be, exp_wd);
      end
      step();
      if (c == k) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!timed_out) begin
      if (!a_we) exp_rdata = a_rdat;
      exp_alo = a_addr[1:0];
      exp_mode = a_mode;
    end
    bus_ack = 1'($urandom);
    bus_rdata = $urandom;
    @(negedge clk);
    checks++;
    if ({done, exc, exc_code, stall, bus_req} !==
        (timed_out ? {1'b0, 1'b1, 5'd7, 2'b00} : {1'b1, 1'b0, 5'd0, 2'b00})) begin
      failures++;
      $display("FAIL %s_resp: got done=%b exc=%b code=%0d stall=%b breq=%b timeout=%b",
               name, done, exc, exc_code, stall, bus_req, timed_out);
    end
    checks++;
    if ({rdata, a_lo, mode_o} !== {exp_rdata, exp_alo, exp_mode}) begin
      failures++;
      $display("FAIL %s_result: got rdata=%h a_lo=%0d mode_o=%0d expected %h %0d %0d",
               name, rdata, a_lo, mode_o, exp_rdata, exp_alo, exp_mode);
    end
    step();
    req = 1'b0;
    bus_ack = 1'($urandom);
    @(negedge clk);
    checks++;
    if ({done, exc, stall, bus_req, rdata} !== {4'b0000, exp_rdata}) begin
      failures++;
      $display("FAIL %s_idle: got ctl=%b rdata=%h expected 0000 %h", name,
               {done, exc, stall, bus_req}, rdata, exp_rdata);
    end
    step();
    bus_ack = 1'b0;
  endtask

  task automatic test_directed();
    run_access(1'b0, 2'd1, 32'h0000_1003, 32'd0, 3, 32'hAABB_CCDD, "load_byte");
    run_access(1'b1, 2'd2, 32'h0000_2002, 32'h0000_BEEF, 1, 32'h5555_5555, "store_half");
    run_access(1'b0, 2'd0, 32'h0000_3001, 32'd0, 1, 32'h0, "load_misaligned");
    run_access(1'b1, 2'd0, 32'h0000_4000, 32'h1234_5678, 0, 32'h0, "store_timeout");
    run_access(1'b0, 2'd0, 32'h0000_5000, 32'd0, TO, 32'hCAFE_F00D, "ack_at_expiry");
    run_access(1'b1, 2'd2, 32'h0000_6003, 32'h0, 1, 32'h0, "store_half_mis");
    run_access(1'b0, 2'd3, 32'h0000_7004, 32'd0, 2, 32'h0BAD_BEEF, "mode3_word");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom), 2'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, TO)), $urandom, "rand");
    end
  endtask

  task automatic test_reset_in_wait();
    req = 1'b1; we = 1'b0; mode = 2'd0; addr = 32'h0000_0040; wdata = 32'd0; bus_ack = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_enter: got bus_req=%b expected 1", bus_req);
    end
    step();
    reset = 1'b1; req = 1'b0;
    step();
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    exp_rdata = 32'd0;
    @(negedge clk);
    checks++;
    if ({bus_req, stall, done, exc, rdata} !== {4'b0000, 32'd0}) begin
      failures++;
      $display("FAIL rst_wait_after: got ctl=%b rdata=%h expected 0000 0",
               {bus_req, stall, done, exc}, rdata);
    end
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, exc, rdata} !== {2'b00, 32'd0}) begin
      failures++;
      $display("FAIL rst_wait_late_ack: got done=%b exc=%b rdata=%h expected 0 0 0", done, exc, rdata);
    end
    step();
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; mode = 2'd0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_reset_in_wait();
    test_directed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
